// File: rtl/mem_bank_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_bank_responder
// Purpose  : Main-memory responder for the cache controller. Four interleaved
//            banks, each occupied for BANK_CYCLES cycles per accepted access.
//            Read data returns after a fixed READ_LAT edges. Per-bank busy
//            lets the initiator schedule word offsets back-to-back across banks.
// Options  : MEM_BANK_CONFLICT_ERR_EN - a busy-bank conflict also raises err.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bank_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int BANK_CYCLES = 4,
  parameter int READ_LAT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        stall,
  output logic [3:0]  busy,
  output logic        err
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam int CNT_W = $clog2(BANK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BANK_CYCLES - 1);

  logic [15:0]           mem_q [WORDS];
  logic [CNT_W-1:0]      cnt_q [4];
  logic [CNT_W-1:0]      cnt_d [4];
  logic [READ_LAT-1:0]   vld_q, vld_d;
  logic [15:0]           dat_q [READ_LAT];
  logic [15:0]           dat_d [READ_LAT];
  logic                  err_q, err_d;

  logic                  req;
  logic                  malformed;
  logic                  accept;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [1:0]            bank;
  logic [DEPTH_LOG2-1:0] idx;

  // Bits above the array index alias onto the same words by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[15:DEPTH_LOG2+1];

  // A bank is busy while its occupancy counter is non-zero.
  for (genvar b = 0; b < 4; b++) begin : g_busy
    assign busy[b] = (cnt_q[b] != '0);
  end

  // Request decode; acceptance looks only at the registered busy bits.
  always_comb begin
    bank      = addr[2:1];
    idx       = addr[DEPTH_LOG2:1];
    req       = rd | wr;
    malformed = (rd & wr) | addr[0];
    stall     = req & ~malformed & busy[bank];
    accept    = req & ~malformed & ~busy[bank];
    rd_acc    = accept & rd;
    wr_acc    = accept & wr;
`ifdef MEM_BANK_CONFLICT_ERR_EN
    err_d     = malformed | stall;
`else
    err_d     = malformed;
`endif
  end

  // Bank counters: load on accept, otherwise count down to zero.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      cnt_d[b] = cnt_q[b];
      if (accept && (bank == 2'(b)))
        cnt_d[b] = CNT_LOAD;
      else if (cnt_q[b] != '0)
        cnt_d[b] = cnt_q[b] - CNT_W'(1);
    end
  end

  // Read pipeline: data stages load only behind a valid, so the output
  // stage keeps the last returned word while data_valid is low.
  always_comb begin
    vld_d    = {vld_q[READ_LAT-1:0], rd_acc} >> 0;
    vld_d[0] = rd_acc;
    dat_d[0] = rd_acc ? mem_q[idx] : dat_q[0];
    for (int i = 1; i < READ_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
    end
  end

  // Control state: bank counters, read pipeline, error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 4; b++) cnt_q[b] <= '0;
      for (int i = 0; i < READ_LAT; i++) dat_q[i] <= '0;
      vld_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int b = 0; b < 4; b++) cnt_q[b] <= cnt_d[b];
      for (int i = 0; i < READ_LAT; i++) dat_q[i] <= dat_d[i];
      vld_q <= vld_d;
      err_q <= err_d;
    end
  end

  // Storage array, cleared on reset, written on an accepted write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
    end else if (wr_acc) begin
      mem_q[idx] <= data_in;
    end
  end

  assign data_out   = dat_q[READ_LAT-1];
  assign data_valid = vld_q[READ_LAT-1];
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bank_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bank_responder
// Purpose  : Self-checking bench for mem_bank_responder. Read responses are
//            predicted from a word-array model and queued with their due cycle;
//            a monitor pops and compares them when data_valid pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bank_responder;

  localparam int DEPTH_LOG2 = 8;
  localparam int READ_LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr;
  logic [15:0] addr, data_in;
  logic [15:0] data_out;
  logic        data_valid, stall, err;
  logic [3:0]  busy;

  typedef struct {
    logic [15:0] d;
    int          c;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_m;
  logic [15:0] mem_m [1 << DEPTH_LOG2];
  logic        err_exp;
  int          cyc_n;
  int          n_chk;
  int          n_pass;

  mem_bank_responder #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .BANK_CYCLES(4),
    .READ_LAT   (READ_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd        (rd),
    .wr        (wr),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .stall     (stall),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Cycle index, stepped on every active edge.
  always @(posedge clk) cyc_n++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
  endtask

  // Response monitor: each data_valid must match the head of the scoreboard
  // both in data and in arrival cycle; overdue entries are reported.
  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() != 0 && sb[0].c < cyc_n) begin
        e_m = sb.pop_front();
        chk("rd_missing_due", cyc_n, e_m.c);
      end
      if (data_valid) begin
        if (sb.size() == 0) begin
          chk("unexp_valid", data_valid, 1'b0);
        end else begin
          e_m = sb.pop_front();
          chk("rd_data", data_out, e_m.d);
          chk("rd_cycle", cyc_n, e_m.c);
        end
      end
    end
  end

  // One request cycle: drive after the edge, check at the falling edge.
  task automatic cyc(input logic i_rd, input logic i_wr, input logic [15:0] a,
                     input logic [15:0] d, input logic exp_stall);
    logic mal;
    logic [DEPTH_LOG2-1:0] ix;
    @(posedge clk);
    #1;
    rd = i_rd; wr = i_wr; addr = a; data_in = d;
    @(negedge clk);
    chk("stall", stall, exp_stall);
    chk("err", err, err_exp);
    mal = (i_rd & i_wr) | a[0];
    ix  = a[DEPTH_LOG2:1];
`ifdef MEM_BANK_CONFLICT_ERR_EN
    err_exp = mal | exp_stall;
`else
    err_exp = mal;
`endif
    if (!mal && !exp_stall) begin
      if (i_rd) sb.push_back('{d: mem_m[ix], c: cyc_n + READ_LAT});
      if (i_wr) mem_m[ix] = d;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc_n = 0; err_exp = 1'b0;
    for (int i = 0; i < (1 << DEPTH_LOG2); i++) mem_m[i] = 16'h0000;
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 16'h0000; data_in = 16'h0000;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_dout", data_out, 16'h0000);
    chk("rst_busy", busy, 4'b0000);
    chk("rst_err", err, 1'b0);
    chk("rst_stall", stall, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset in the cycle after an accepted read discards it
    cyc(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(posedge clk);
    #1;
    rd = 1'b0; rst = 1'b1;
    sb.delete();
    err_exp = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 4'b0000);
    chk("midrst_valid", data_valid, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(4);
    chk("postrst_busy", busy, 4'b0000);
    chk("postrst_err", err, 1'b0);

    // Write then read back; bank still busy at T+3, free at T+4
    cyc(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
    idle(1);
    chk("wr_busy", busy, 4'b0001);
    idle(1);
    cyc(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1);
    cyc(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    idle(3);

    // Upper address bits alias onto the same word
    cyc(1'b0, 1'b1, 16'h0210, 16'hA5A5, 1'b0);
    idle(3);
    cyc(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    idle(3);

    // Interleaved burst across banks 0..3
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b1, 16'h0100 + 16'(2 * i), 16'h1000 + 16'(i * 16'h0111), 1'b0);
    idle(3);
    cyc(1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0);
    chk("burst_busy0", busy, 4'b0000);
    cyc(1'b1, 1'b0, 16'h0102, 16'h0000, 1'b0);
    chk("burst_busy1", busy, 4'b0001);
    cyc(1'b1, 1'b0, 16'h0104, 16'h0000, 1'b0);
    chk("burst_busy2", busy, 4'b0011);
    cyc(1'b1, 1'b0, 16'h0106, 16'h0000, 1'b0);
    chk("burst_busy3", busy, 4'b0111);
    idle(1);
    chk("burst_busy4", busy, 4'b1110);
    idle(3);

    // Same-bank conflict: dropped, then accepted when re-issued at T+4
    cyc(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    cyc(1'b1, 1'b0, 16'h0008, 16'h0000, 1'b1);
    idle(2);
    cyc(1'b1, 1'b0, 16'h0008, 16'h0000, 1'b0);
    idle(4);

    // Malformed requests: no access, no occupancy, err the next cycle
    cyc(1'b0, 1'b1, 16'h0020, 16'h1234, 1'b0);
    cyc(1'b1, 1'b1, 16'h0020, 16'hDEAD, 1'b0);
    chk("mal_busy0", busy, 4'b0001);
    cyc(1'b1, 1'b0, 16'h0021, 16'h0000, 1'b0);
    chk("mal_busy1", busy, 4'b0001);
    idle(1);
    chk("mal_busy2", busy, 4'b0001);
    cyc(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
    idle(4);

    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
